mod_mem_arbiter: RTL and testbench

- Shares one single-port external memory between the core's instruction fetch and its load/store accesses.
- Sits between mod_mips_processor and the memory bus.
- Sequences each instruction through fetch, optional data access and commit, and stalls the core with hold while memory is busy.
- Provides a one-cycle commit strobe that gates register-file writes, plus a bus-timeout error.

---
 rtl/mips_defs.sv | 21 ++
 rtl/mod_bus_timeout.sv | 38 +++
 rtl/mod_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mod_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the MIPS core memory path: arbiter state encodings
// and the instruction value loaded into the fetch register on reset.
package mips_defs;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DATA,
        S_COMMIT,
        S_ERROR
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    // An instruction needs a data phase when it decodes as a load or a store.
    function automatic logic mem_access(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/mod_bus_timeout.sv
// Counts consecutive cycles a bus request waits for its acknowledge and
// flags expiry on the cycle the count reaches TIMEOUT_CYCLES (0 disables).
module mod_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic i_ack,
    input  logic i_clear,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_waiting;

    assign w_waiting = i_req && !i_ack && (TIMEOUT_CYCLES != 0);

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values of its inputs, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (!w_waiting || i_clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Fires during the unacknowledged cycle that would make the count hit the limit.
    assign o_expire = w_waiting && (r_count == LAST_COUNT);

endmodule

// File: rtl/mod_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// sequencing fetch -> exec -> optional data -> commit and stalling the core.
module mod_mem_arbiter
    import mips_defs::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] core_pc,
    input  logic [ADDR_W-1:0] core_data_address,
    input  logic              core_mem_read,
    input  logic              core_mem_write,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] data,
    output logic              hold,
    output logic              core_commit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_error
);

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_instruction;
    logic [DATA_W-1:0] r_data;
    logic              r_bus_error;
    logic              w_req_state;
    logic              w_expire;
    logic              w_state_change;
    logic              w_access;
    logic              w_capture_instr;
    logic              w_capture_data;

    assign w_access       = mem_access(core_mem_read, core_mem_write);
    assign w_req_state    = (r_state == S_FETCH) || (r_state == S_DATA);
    assign w_state_change = (w_next_state != r_state);

    mod_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_bus_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_req    (w_req_state),
        .i_ack    (mem_ack),
        .i_clear  (w_state_change),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned, which would infer a latch.
        w_next_state    = r_state;
        hold            = 1'b1;
        core_commit     = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = core_pc;
        mem_wdata       = core_wdata;
        w_capture_instr = 1'b0;
        w_capture_data  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (w_expire) begin
                    w_next_state = S_ERROR;
                end else if (mem_ack) begin
                    w_capture_instr = 1'b1;
                    w_next_state    = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!w_access) begin
                    hold         = 1'b0;
                    core_commit  = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                // A store takes priority when the core flags both read and write.
                mem_req  = 1'b1;
                mem_we   = core_mem_write;
                mem_addr = core_data_address;
                if (w_expire) begin
                    w_next_state = S_ERROR;
                end else if (mem_ack) begin
                    w_capture_data = !core_mem_write;
                    w_next_state   = S_COMMIT;
                end
            end
            S_COMMIT: begin
                hold         = 1'b0;
                core_commit  = 1'b1;
                w_next_state = S_FETCH;
            end
            S_ERROR: begin
                w_next_state = S_ERROR;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instruction <= DATA_W'(NOP_INSTR);
            r_data        <= '0;
            r_bus_error   <= 1'b0;
        end else begin
            if (w_capture_instr) begin
                r_instruction <= mem_rdata;
            end
            if (w_capture_data) begin
                r_data <= mem_rdata;
            end
            if (w_expire) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    assign instruction = r_instruction;
    assign data        = r_data;
    assign bus_error   = r_bus_error;

endmodule

// File: tb/tb_mod_mem_arbiter.sv
// Self-checking bench for mod_mem_arbiter: table-driven instruction vectors
// with a bus-transaction scoreboard, plus reset and timeout sequences.
module tb_mod_mem_arbiter;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rd;
        logic        wr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          fw;
        int          dw;
        logic        sp;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] data;
    } commit_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] core_pc;
    logic [31:0] core_data_address;
    logic        core_mem_read;
    logic        core_mem_write;
    logic [31:0] core_wdata;
    logic [31:0] instruction;
    logic [31:0] data;
    logic        hold;
    logic        core_commit;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_error;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          n_commits = 0;
    logic [31:0] exp_data;
    txn_t        sb_q[$];
    commit_t     cm_q[$];
    vec_t        vecs[6];

    always #5 clk = ~clk;

    mod_mem_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .core_pc           (core_pc),
        .core_data_address (core_data_address),
        .core_mem_read     (core_mem_read),
        .core_mem_write    (core_mem_write),
        .core_wdata        (core_wdata),
        .instruction       (instruction),
        .data              (data),
        .hold              (hold),
        .core_commit       (core_commit),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack),
        .bus_error         (bus_error)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_expect();
        sb_q.delete();
        cm_q.delete();
        exp_data = '0;
    endtask

    // Acts as the core: presents the decoded instruction and records what the bus should see.
    task automatic set_core(input vec_t v);
        txn_t    t;
        commit_t c;
        core_pc           = v.pc;
        core_data_address = v.daddr;
        core_mem_read     = v.rd;
        core_mem_write    = v.wr;
        core_wdata        = v.wdata;
        mem_ack           = 1'b0;
        t = '{we: 1'b0, addr: v.pc, wdata: 32'h0};
        sb_q.push_back(t);
        if (v.rd || v.wr) begin
            t = '{we: v.wr, addr: v.daddr, wdata: v.wdata};
            sb_q.push_back(t);
        end
        if (v.rd && !v.wr) exp_data = v.rdata;
        c = '{instr: v.instr, data: exp_data};
        cm_q.push_back(c);
    endtask

    // Runs one instruction starting in its first fetch cycle; ends just after the commit edge.
    task automatic run_instr(input vec_t v);
        logic    acc;
        logic    exp_req;
        int      lat;
        txn_t    t;
        commit_t c;
        acc = v.rd || v.wr;
        lat = acc ? v.fw + v.dw + 4 : v.fw + 2;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            @(negedge clk);
            exp_req = (cyc <= v.fw + 1) || (acc && cyc >= v.fw + 3 && cyc <= v.fw + v.dw + 3);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (cyc == v.fw + 1) begin
                mem_ack   = 1'b1;
                mem_rdata = v.instr;
            end else if (acc && cyc == v.fw + v.dw + 3) begin
                mem_ack   = 1'b1;
                mem_rdata = v.rdata;
            end else if (!exp_req && v.sp) begin
                mem_ack = 1'b1;
            end
            check("mem_req", mem_req, exp_req);
            if (mem_req) begin
                if (sb_q.size() == 0) begin
                    check("bus_txn_expected", 1'b1, 1'b0);
                end else begin
                    t = sb_q[0];
                    check("mem_we", mem_we, t.we);
                    check("mem_addr", mem_addr, t.addr);
                    if (t.we) check("mem_wdata", mem_wdata, t.wdata);
                    if (mem_ack) void'(sb_q.pop_front());
                end
            end
            check("hold", hold, cyc != lat);
            check("core_commit", core_commit, cyc == lat);
            check("bus_error", bus_error, 1'b0);
            if (cyc == v.fw + 2) check("instruction", instruction, v.instr);
            if (core_commit) begin
                n_commits++;
                if (cm_q.size() == 0) begin
                    check("commit_expected", 1'b1, 1'b0);
                end else begin
                    c = cm_q.pop_front();
                    check("commit_instr", instruction, c.instr);
                    check("commit_data", data, c.data);
                end
            end
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        vec_t rv;
        vecs[0] = '{pc: 32'h000, instr: 32'h012A4020, rd: 1'b0, wr: 1'b0, daddr: 32'h0,
                    wdata: 32'h0, rdata: 32'h0, fw: 0, dw: 0, sp: 1'b0};
        vecs[1] = '{pc: 32'h004, instr: 32'h8C880004, rd: 1'b1, wr: 1'b0, daddr: 32'h104,
                    wdata: 32'h0, rdata: 32'hDEADBEEF, fw: 0, dw: 2, sp: 1'b0};
        vecs[2] = '{pc: 32'h008, instr: 32'hAC880200, rd: 1'b1, wr: 1'b1, daddr: 32'h200,
                    wdata: 32'h12345678, rdata: 32'hCAFEF00D, fw: 1, dw: 0, sp: 1'b0};
        vecs[3] = '{pc: 32'h00C, instr: 32'h01095020, rd: 1'b0, wr: 1'b0, daddr: 32'h0,
                    wdata: 32'h0, rdata: 32'h0, fw: 3, dw: 0, sp: 1'b1};
        vecs[4] = '{pc: 32'h010, instr: 32'h8C0A03FC, rd: 1'b1, wr: 1'b0, daddr: 32'h3FC,
                    wdata: 32'h0, rdata: 32'hA5A55A5A, fw: 2, dw: 3, sp: 1'b1};
        vecs[5] = '{pc: 32'h014, instr: 32'hAC0B0400, rd: 1'b0, wr: 1'b1, daddr: 32'h400,
                    wdata: 32'h0BADF00D, rdata: 32'h0, fw: 0, dw: 1, sp: 1'b1};

        reset             = 1'b1;
        core_pc           = '0;
        core_data_address = '0;
        core_mem_read     = 1'b0;
        core_mem_write    = 1'b0;
        core_wdata        = '0;
        mem_rdata         = '0;
        mem_ack           = 1'b0;
        clear_expect();
        repeat (2) @(negedge clk);
        check("rst_instruction", instruction, 32'h0);
        check("rst_data", data, 32'h0);
        check("rst_hold", hold, 1'b1);
        check("rst_commit", core_commit, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_bus_error", bus_error, 1'b0);

        set_core(vecs[0]);
        reset = 1'b0;
        check("idle_hold", hold, 1'b1);
        check("idle_mem_req", mem_req, 1'b0);

        for (int i = 0; i < 6; i++) begin
            if (i > 0) set_core(vecs[i]);
            run_instr(vecs[i]);
        end

        // Random-wait stream with spurious acks: one commit per instruction.
        n_commits = 0;
        for (int k = 0; k < 10; k++) begin
            rv.pc    = $urandom & 32'hFFFF_FFFC;
            rv.instr = $urandom;
            rv.rd    = 1'($urandom_range(0, 1));
            rv.wr    = 1'($urandom_range(0, 1));
            rv.daddr = $urandom & 32'hFFFF_FFFC;
            rv.wdata = $urandom;
            rv.rdata = $urandom;
            rv.fw    = int'($urandom_range(0, 3));
            rv.dw    = int'($urandom_range(0, 3));
            rv.sp    = 1'b1;
            set_core(rv);
            run_instr(rv);
        end
        check("stream_commits", n_commits, 10);

        // Reset asserted between edges while a load waits in the data phase.
        rv = '{pc: 32'h080, instr: 32'h8C000010, rd: 1'b1, wr: 1'b0, daddr: 32'h500,
               wdata: 32'h0, rdata: 32'h77777777, fw: 0, dw: 9, sp: 1'b0};
        set_core(rv);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = rv.instr;
        check("mid_fetch_addr", mem_addr, 32'h080);
        @(negedge clk);
        mem_ack = 1'b0;
        check("mid_exec_req", mem_req, 1'b0);
        @(negedge clk);
        check("mid_data_req", mem_req, 1'b1);
        check("mid_data_addr", mem_addr, 32'h500);
        #2;
        mem_rdata = rv.rdata;
        reset     = 1'b1;
        #1;
        check("async_rst_mem_req", mem_req, 1'b0);
        check("async_rst_hold", hold, 1'b1);
        check("async_rst_commit", core_commit, 1'b0);
        check("async_rst_data", data, 32'h0);
        clear_expect();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("in_rst_commit", core_commit, 1'b0);
        end
        rv = '{pc: 32'h000, instr: 32'h00000020, rd: 1'b0, wr: 1'b0, daddr: 32'h0,
               wdata: 32'h0, rdata: 32'h0, fw: 1, dw: 0, sp: 1'b1};
        set_core(rv);
        reset = 1'b0;
        check("post_rst_idle_req", mem_req, 1'b0);
        run_instr(rv);

        // Fetch never acknowledged: four request cycles then a sticky error.
        reset = 1'b1;
        clear_expect();
        rv = '{pc: 32'h040, instr: 32'h0, rd: 1'b0, wr: 1'b0, daddr: 32'h0,
               wdata: 32'h0, rdata: 32'h0, fw: 0, dw: 0, sp: 1'b0};
        set_core(rv);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            check("to_wait_req", mem_req, 1'b1);
            check("to_wait_addr", mem_addr, 32'h040);
            check("to_wait_err", bus_error, 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mem_ack = 1'($urandom_range(0, 1));
            check("to_err_flag", bus_error, 1'b1);
            check("to_err_req", mem_req, 1'b0);
            check("to_err_hold", hold, 1'b1);
            check("to_err_commit", core_commit, 1'b0);
        end
        #2;
        reset = 1'b1;
        #1;
        check("to_rst_err", bus_error, 1'b0);
        check("to_rst_hold", hold, 1'b1);
        @(negedge clk);
        mem_ack = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        check("to_refetch_req", mem_req, 1'b1);
        check("to_refetch_err", bus_error, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
